rfid_pie_decoder: RTL and testbench

Front-end pulse-interval-encoding (PIE) decoder for the tag's uplink. It sits directly upstream of `rfid_receive`. It takes the demodulated reader envelope, oversampled by the system clock, and recovers the frame delimiter, data-0 (Tari), RTcal and optional TRcal. It then emits one decoded bit per symbol as a `UL_data` / `UL_clock` pair, which `rfid_receive` shifts into its packet register. It also reports the measured link-timing values for the backscatter timing logic.

---
 rtl/rfid_pie_decoder.sv | 231 +++++++++++++++++++++++
 tb/tb_rfid_pie_decoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rfid_pie_decoder.sv
`timescale 1ns/1ps
// PIE front end for the tag uplink: recovers delimiter, Tari, RTcal and optional TRcal,
// then emits one decoded bit per symbol on UL_data/UL_clock for rfid_receive.
module rfid_pie_decoder #(
    parameter int CNT_W     = 12,
    parameter int DELIM_MIN = 20,
    parameter int DELIM_MAX = 40
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             env_in,
    output logic             UL_data,
    output logic             UL_clock,
    output logic             frame_active,
    output logic             frame_done,
    output logic             frame_err,
    output logic             trcal_seen,
    output logic [CNT_W-1:0] tari,
    output logic [CNT_W-1:0] rtcal,
    output logic [CNT_W-1:0] trcal,
    output logic [7:0]       bit_count
);

    typedef enum logic [2:0] {IDLE, DELIM, TARI, RTCAL, PRE, DATA} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] DMIN    = CNT_W'(DELIM_MIN);
    localparam logic [CNT_W-1:0] DMAX    = CNT_W'(DELIM_MAX);

    state_t           state, state_n;
    logic             env_meta, env_sync, env_lvl, rise, fall;
    logic [CNT_W-1:0] cnt, lcnt, pivot;
    logic [CNT_W+1:0] cnt_w, tari_x2, tari_x4, rtcal_x2;
    logic             enter_delim, emit, fail, finish, low_err, delim_ok;
    logic [CNT_W-1:0] tari_n, rtcal_n, trcal_n;
    logic             seen_n, active_n, done_n, err_n, strobe_n, data_n;
    logic [7:0]       bits_n;

    // env_lvl trails the synchronizer by one stage so it lines up with the registered edge pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            env_meta <= 1'b1;
            env_sync <= 1'b1;
            env_lvl  <= 1'b1;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            env_meta <= env_in;
            env_sync <= env_meta;
            env_lvl  <= env_sync;
            rise     <= env_sync & ~env_lvl;
            fall     <= ~env_sync & env_lvl;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt  <= '0;
            lcnt <= '0;
        end else begin
            if (rise || enter_delim) begin
                cnt <= CNT_ONE;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_ONE;
            end

            if (rise) begin
                lcnt <= '0;
            end else if (!env_lvl && lcnt != CNT_MAX) begin
                lcnt <= lcnt + CNT_ONE;
            end
        end
    end

    assign pivot    = {1'b0, rtcal[CNT_W-1:1]};
    assign cnt_w    = {2'b00, cnt};
    assign tari_x2  = {1'b0, tari, 1'b0};
    assign tari_x4  = {tari, 2'b00};
    assign rtcal_x2 = {1'b0, rtcal, 1'b0};
    assign delim_ok = (lcnt >= DMIN) && (lcnt <= DMAX);

    // Before RTcal is known the low pulse is bounded by Tari; tari itself is still open in TARI.
    always_comb begin
        low_err = 1'b0;
        if (!env_lvl) begin
            if (cnt == CNT_MAX) begin
                low_err = 1'b1;
            end
            case (state)
                RTCAL:     if (lcnt > tari)  low_err = 1'b1;
                PRE, DATA: if (lcnt > pivot) low_err = 1'b1;
                default:   ;
            endcase
        end
    end

    always_comb begin
        state_n     = state;
        enter_delim = 1'b0;
        emit        = 1'b0;
        fail        = 1'b0;
        finish      = 1'b0;
        tari_n      = tari;
        rtcal_n     = rtcal;
        trcal_n     = trcal;
        seen_n      = trcal_seen;
        bits_n      = bit_count;
        active_n    = frame_active;
        done_n      = 1'b0;
        err_n       = 1'b0;
        strobe_n    = 1'b0;
        data_n      = 1'b0;

        case (state)
            // Wait for a fresh fall so a low already in progress is never mistaken for a delimiter.
            IDLE: begin
                active_n = 1'b0;
                if (fall) begin
                    state_n     = DELIM;
                    enter_delim = 1'b1;
                end
            end
            DELIM: begin
                if (rise) begin
                    if (delim_ok) begin
                        active_n = 1'b1;
                        trcal_n  = '0;
                        seen_n   = 1'b0;
                        bits_n   = '0;
                        state_n  = TARI;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            TARI: begin
                if (rise) begin
                    tari_n  = cnt;
                    state_n = RTCAL;
                end else if (low_err) begin
                    fail = 1'b1;
                end
            end
            RTCAL: begin
                if (rise) begin
                    rtcal_n = cnt;
                    if (cnt_w > tari_x2 && cnt_w < tari_x4) begin
                        state_n = PRE;
                    end else begin
                        fail = 1'b1;
                    end
                end else if (low_err) begin
                    fail = 1'b1;
                end
            end
            PRE: begin
                if (rise) begin
                    if (cnt > rtcal) begin
                        trcal_n = cnt;
                        seen_n  = 1'b1;
                    end else begin
                        emit = 1'b1;
                    end
                    state_n = DATA;
                end else if (low_err) begin
                    fail = 1'b1;
                end else if (env_lvl && cnt_w >= rtcal_x2) begin
                    finish = 1'b1;
                end
            end
            DATA: begin
                if (rise) begin
                    emit = 1'b1;
                end else if (low_err) begin
                    fail = 1'b1;
                end else if (env_lvl && cnt_w >= rtcal_x2) begin
                    finish = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (emit) begin
            strobe_n = 1'b1;
            data_n   = (cnt > pivot);
            if (bit_count != 8'hFF) begin
                bits_n = bit_count + 8'd1;
            end
        end

        if (fail) begin
            err_n    = 1'b1;
            active_n = 1'b0;
            state_n  = IDLE;
        end else if (finish) begin
            done_n   = 1'b1;
            active_n = 1'b0;
            state_n  = IDLE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            tari         <= '0;
            rtcal        <= '0;
            trcal        <= '0;
            trcal_seen   <= 1'b0;
            bit_count    <= '0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
            UL_clock     <= 1'b0;
            UL_data      <= 1'b0;
        end else begin
            state        <= state_n;
            tari         <= tari_n;
            rtcal        <= rtcal_n;
            trcal        <= trcal_n;
            trcal_seen   <= seen_n;
            bit_count    <= bits_n;
            frame_active <= active_n;
            frame_done   <= done_n;
            frame_err    <= err_n;
            UL_clock     <= strobe_n;
            UL_data      <= data_n;
        end
    end

endmodule

// File: tb/tb_rfid_pie_decoder.sv
`timescale 1ns/1ps
// Directed bench for rfid_pie_decoder: drives PIE frames cycle by cycle from one
// initial block and checks decoded bits, measured timing and frame status.
module tb_rfid_pie_decoder;

    localparam int CNT_W = 12;
    localparam int PW    = 12;

    logic             clock = 1'b0;
    logic             reset;
    logic             env_in;
    logic             UL_data, UL_clock, frame_active, frame_done, frame_err, trcal_seen;
    logic [CNT_W-1:0] tari, rtcal, trcal;
    logic [7:0]       bit_count;

    rfid_pie_decoder #(.CNT_W(CNT_W), .DELIM_MIN(20), .DELIM_MAX(40)) dut (
        .clock        (clock),
        .reset        (reset),
        .env_in       (env_in),
        .UL_data      (UL_data),
        .UL_clock     (UL_clock),
        .frame_active (frame_active),
        .frame_done   (frame_done),
        .frame_err    (frame_err),
        .trcal_seen   (trcal_seen),
        .tari         (tari),
        .rtcal        (rtcal),
        .trcal        (trcal),
        .bit_count    (bit_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic strobe_bits [0:511];
    int   strobe_cyc  [0:511];
    int   n_strobe = 0, n_done = 0, n_err = 0, n_both = 0, n_active = 0, done_cyc = 0;

    // Event log sampled mid-cycle; the main sequence compares against snapshots of these counts.
    always @(negedge clock) begin
        if (UL_clock === 1'b1) begin
            strobe_bits[n_strobe % 512] = UL_data;
            strobe_cyc[n_strobe % 512]  = cyc;
            n_strobe++;
        end
        if (frame_done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
        end
        if (frame_err === 1'b1) n_err++;
        if (frame_done === 1'b1 && frame_err === 1'b1) n_both++;
        if (frame_active === 1'b1) n_active++;
    end

    int checks = 0, passed = 0, errors = 0, last_rise = 0, first_rise = 0;
    int base_s, base_d, base_e, base_a;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) begin
            passed++;
        end else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic level, input int cycles);
        if (level && !env_in) last_rise = cyc + 1;
        env_in = level;
        repeat (cycles) @(negedge clock);
    endtask

    task automatic sendSymbol(input int interval);
        applyStimulus(1'b1, interval - PW);
        applyStimulus(1'b0, PW);
    endtask

    task automatic sendPreamble(input int trcal_len);
        applyStimulus(1'b0, 30);
        sendSymbol(25);
        sendSymbol(70);
        if (trcal_len != 0) sendSymbol(trcal_len);
    endtask

    task automatic sendBits(input logic [31:0] pattern, input int n);
        for (int i = n - 1; i >= 0; i--) sendSymbol(pattern[i] ? 45 : 25);
    endtask

    function automatic logic [31:0] collectBits(input int base, input int n);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < n; i++) w = {w[30:0], strobe_bits[(base + i) % 512]};
        return w;
    endfunction

    task automatic snapshot();
        base_s = n_strobe;
        base_d = n_done;
        base_e = n_err;
        base_a = n_active;
    endtask

    initial begin
        reset  = 1'b1;
        env_in = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("reset_tari", tari, 0);
        checkOutput("reset_bit_count", bit_count, 0);
        checkOutput("reset_active", frame_active, 0);
        checkOutput("reset_ul_clock", UL_clock, 0);
        reset = 1'b0;
        applyStimulus(1'b1, 10);

        // Basic frame: bits 0,1,1,0 without TRcal
        snapshot();
        sendPreamble(0);
        checkOutput("t1_active_mid", frame_active, 1);
        sendSymbol(25);
        sendSymbol(45);
        first_rise = last_rise;
        sendSymbol(45);
        sendSymbol(25);
        applyStimulus(1'b1, 150);
        checkOutput("t1_tari", tari, 25);
        checkOutput("t1_rtcal", rtcal, 70);
        checkOutput("t1_trcal_seen", trcal_seen, 0);
        checkOutput("t1_strobes", n_strobe - base_s, 4);
        checkOutput("t1_bits", collectBits(base_s, 4), 32'h6);
        checkOutput("t1_bit_count", bit_count, 4);
        checkOutput("t1_done", n_done - base_d, 1);
        checkOutput("t1_done_latency", done_cyc - last_rise, 143);
        checkOutput("t1_strobe_latency", strobe_cyc[base_s % 512] - first_rise, 3);
        checkOutput("t1_active_end", frame_active, 0);
        checkOutput("t1_no_err", n_err - base_e, 0);

        // Query preamble with TRcal 150 and 22 data bits
        snapshot();
        sendPreamble(150);
        sendBits(32'h002C_5A93, 22);
        applyStimulus(1'b1, 150);
        checkOutput("t2_trcal", trcal, 150);
        checkOutput("t2_trcal_seen", trcal_seen, 1);
        checkOutput("t2_strobes", n_strobe - base_s, 22);
        checkOutput("t2_bits", collectBits(base_s, 22), 32'h002C_5A93);
        checkOutput("t2_bit_count", bit_count, 22);
        checkOutput("t2_done", n_done - base_d, 1);
        checkOutput("t2_done_latency", done_cyc - last_rise, 143);

        // Delimiters too short and too long are dropped silently
        snapshot();
        applyStimulus(1'b0, 15);
        applyStimulus(1'b1, 20);
        applyStimulus(1'b0, 50);
        applyStimulus(1'b1, 20);
        checkOutput("t3_no_active", n_active - base_a, 0);
        checkOutput("t3_no_err", n_err - base_e, 0);
        sendPreamble(0);
        sendBits(32'h2, 2);
        applyStimulus(1'b1, 150);
        checkOutput("t3_strobes", n_strobe - base_s, 2);
        checkOutput("t3_bits", collectBits(base_s, 2), 32'h2);
        checkOutput("t3_done", n_done - base_d, 1);
        checkOutput("t3_trcal_cleared", trcal_seen, 0);

        // RTcal of 40 against Tari 25 is below 2*Tari
        snapshot();
        applyStimulus(1'b0, 30);
        sendSymbol(25);
        sendSymbol(40);
        applyStimulus(1'b1, 20);
        checkOutput("t4_err", n_err - base_e, 1);
        checkOutput("t4_active", frame_active, 0);
        checkOutput("t4_strobes", n_strobe - base_s, 0);
        checkOutput("t4_no_done", n_done - base_d, 0);

        // Pivot boundary 35 -> 0, 36 -> 1, then a 40-clock low corrupts the frame
        snapshot();
        sendPreamble(0);
        sendSymbol(35);
        sendSymbol(36);
        applyStimulus(1'b1, 10);
        applyStimulus(1'b0, 40);
        applyStimulus(1'b1, 160);
        checkOutput("t5_strobes", n_strobe - base_s, 2);
        checkOutput("t5_bits", collectBits(base_s, 2), 32'h1);
        checkOutput("t5_err", n_err - base_e, 1);
        checkOutput("t5_no_done", n_done - base_d, 0);
        checkOutput("t5_active", frame_active, 0);

        // Reset during DATA clears everything and suppresses frame_done
        snapshot();
        sendPreamble(0);
        sendBits(32'h5, 3);
        applyStimulus(1'b1, 5);
        checkOutput("t6_pre_reset_bits", collectBits(base_s, 3), 32'h5);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("t6_reset_tari", tari, 0);
        checkOutput("t6_reset_rtcal", rtcal, 0);
        checkOutput("t6_reset_bit_count", bit_count, 0);
        checkOutput("t6_reset_active", frame_active, 0);
        applyStimulus(1'b1, 160);
        checkOutput("t6_no_done", n_done - base_d, 0);
        checkOutput("t6_no_err", n_err - base_e, 0);
        snapshot();
        sendPreamble(0);
        sendBits(32'h3, 3);
        applyStimulus(1'b1, 150);
        checkOutput("t6_after_bits", collectBits(base_s, 3), 32'h3);
        checkOutput("t6_after_strobes", n_strobe - base_s, 3);
        checkOutput("t6_after_done", n_done - base_d, 1);
        checkOutput("t6_after_tari", tari, 25);

        checkOutput("done_err_overlap", n_both, 0);

        $display("[TB] error count %0d", errors);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
